sevseg_scan_mux: RTL and testbench

- Parametrised multiplexed seven-segment display driver. Next generation of the four-digit SevSeg peripheral on the Basys3 board.
- Scans DIGITS common-anode digits and decodes hex nibbles.
- Adds per-digit enable, decimal points, PWM brightness, tear-free double-buffered value loading and a frame-boundary strobe.
- Sits between the uC register bus and the board an/seg pins.

---
 rtl/sevseg_scan_mux.sv | 182 ++++++++++++++++++
 tb/tb_sevseg_scan_mux.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan_mux.sv
// Multiplexed common-anode seven-segment driver with PWM dimming and frame-synchronous double buffering.
// Optional leading-zero suppression is enabled by defining SEVSEG_LZ_SUPPRESS_EN.
module sevseg_scan_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [SLOT_W-1:0]   slot_cnt_r;
    logic [IDX_W-1:0]    digit_idx_r;
    logic [BRIGHT_W-1:0] pwm_cnt_r;
    logic [4*DIGITS-1:0] shadow_value_r, active_value_r;
    logic [DIGITS-1:0]   shadow_dp_r, active_dp_r;
    logic [DIGITS-1:0]   shadow_en_r, active_en_r;
    logic                pending_r;
    logic [DIGITS-1:0]   an_r;
    logic [7:0]          seg_r;
    logic                frame_tick_r;

    logic                boundary_s;
    logic [DIGITS-1:0]   lz_mask_s;
    logic [DIGITS-1:0]   an_on_s;
    logic [3:0]          nib_s;
    logic                dp_s;
    logic                en_s;
    logic                lz_s;
    logic                bright_ok_s;
    logic                digit_on_s;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    assign boundary_s = (slot_cnt_r == SLOT_LAST) && (digit_idx_r == IDX_LAST);

    // Slot, digit and PWM counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_r  <= '0;
            digit_idx_r <= '0;
            pwm_cnt_r   <= '0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + BRIGHT_W'(1);
            if (slot_cnt_r == SLOT_LAST) begin
                slot_cnt_r <= '0;
                if (digit_idx_r == IDX_LAST) begin
                    digit_idx_r <= '0;
                end else begin
                    digit_idx_r <= digit_idx_r + IDX_W'(1);
                end
            end else begin
                slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
            end
        end
    end

    // Shadow capture and frame-boundary transfer; a load coinciding with the boundary keeps pending set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value_r <= '0;
            shadow_dp_r    <= '0;
            shadow_en_r    <= '0;
            active_value_r <= '0;
            active_dp_r    <= '0;
            active_en_r    <= '0;
            pending_r      <= 1'b0;
        end else begin
            if (boundary_s && pending_r) begin
                active_value_r <= shadow_value_r;
                active_dp_r    <= shadow_dp_r;
                active_en_r    <= shadow_en_r;
            end
            if (load) begin
                shadow_value_r <= value;
                shadow_dp_r    <= dp_in;
                shadow_en_r    <= digit_en;
                pending_r      <= 1'b1;
            end else if (boundary_s) begin
                pending_r <= 1'b0;
            end
        end
    end

`ifdef SEVSEG_LZ_SUPPRESS_EN
    logic seen_nz_s;

    // Blank zero digits above the most significant nonzero nibble; digit 0 always shows
    always_comb begin
        lz_mask_s = '0;
        seen_nz_s = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            seen_nz_s    = seen_nz_s | (active_value_r[i*4 +: 4] != 4'h0);
            lz_mask_s[i] = ~seen_nz_s;
        end
    end
`else
    assign lz_mask_s = '0;
`endif

    // Select the data for the digit currently being scanned
    always_comb begin
        nib_s   = 4'h0;
        dp_s    = 1'b0;
        en_s    = 1'b0;
        lz_s    = 1'b0;
        an_on_s = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx_r == IDX_W'(i)) begin
                nib_s      = active_value_r[i*4 +: 4];
                dp_s       = active_dp_r[i];
                en_s       = active_en_r[i];
                lz_s       = lz_mask_s[i];
                an_on_s[i] = 1'b0;
            end else begin
                an_on_s[i] = 1'b1;
            end
        end
    end

    // Slot cycle 0 is kept dark so the anode switch never overlaps segment changes
    assign bright_ok_s = (brightness == '1) || (pwm_cnt_r < brightness);
    assign digit_on_s  = en_s && (slot_cnt_r != '0) && bright_ok_s && !lz_s;

    // Registered pin drive and frame strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r         <= '1;
            seg_r        <= 8'hFF;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= boundary_s;
            if (digit_on_s) begin
                an_r  <= an_on_s;
                seg_r <= {~dp_s, hex7(nib_s)};
            end else begin
                an_r  <= '1;
                seg_r <= 8'hFF;
            end
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_sevseg_scan_mux.sv
// Directed bench for sevseg_scan_mux at DIGITS=4, REFRESH_DIV=8 (one frame = 32 cycles).
module tb_sevseg_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        load = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sevseg_scan_mux #(.DIGITS(4), .REFRESH_DIV(8), .BRIGHT_W(4)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .load(load), .brightness(brightness), .an(an), .seg(seg), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Edge count since reset release; after edge c the pins reflect counter state c-1
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

`ifdef SEVSEG_LZ_SUPPRESS_EN
    localparam logic [3:0] LZ_AN2 = 4'hF;  localparam logic [7:0] LZ_SEG2 = 8'hFF;
    localparam logic [3:0] LZ_AN3 = 4'hF;  localparam logic [7:0] LZ_SEG3 = 8'hFF;
`else
    localparam logic [3:0] LZ_AN2 = 4'hB;  localparam logic [7:0] LZ_SEG2 = 8'hC0;
    localparam logic [3:0] LZ_AN3 = 4'h7;  localparam logic [7:0] LZ_SEG3 = 8'hC0;
`endif

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  br;
        int          s;
        logic [3:0]  exp_an;
        logic [7:0]  exp_seg;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_an", {12'h0, an}, 16'h000F);
        chk("reset_seg", {8'h0, seg}, 16'h00FF);
        chk("reset_tick", {15'h0, frame_tick}, 16'h0000);
        rst = 1'b0;
    endtask

    // Reset, then capture the given data on edge 1; it becomes active at edge 32
    task automatic start(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                         input logic [3:0] br);
        do_reset();
        value = v; dp_in = dp; digit_en = en; brightness = br;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h1234, 4'h0, 4'hF, 4'hF, 0,  4'hF, 8'hFF};
        vecs[1]  = '{16'h1234, 4'h0, 4'hF, 4'hF, 3,  4'hE, 8'h99};
        vecs[2]  = '{16'h1234, 4'h0, 4'hF, 4'hF, 11, 4'hD, 8'hB0};
        vecs[3]  = '{16'h1234, 4'h0, 4'hF, 4'hF, 19, 4'hB, 8'hA4};
        vecs[4]  = '{16'h1234, 4'h0, 4'hF, 4'hF, 27, 4'h7, 8'hF9};
        vecs[5]  = '{16'h1234, 4'h0, 4'hF, 4'hF, 8,  4'hF, 8'hFF};
        vecs[6]  = '{16'h1234, 4'h0, 4'hF, 4'hF, 15, 4'hD, 8'hB0};
        vecs[7]  = '{16'h1234, 4'h0, 4'hF, 4'hE, 13, 4'hD, 8'hB0};
        vecs[8]  = '{16'h1234, 4'h0, 4'hF, 4'hE, 14, 4'hF, 8'hFF};
        vecs[9]  = '{16'h1234, 4'h0, 4'hF, 4'h4, 2,  4'hE, 8'h99};
        vecs[10] = '{16'h1234, 4'h0, 4'hF, 4'h4, 5,  4'hF, 8'hFF};
        vecs[11] = '{16'h1234, 4'h0, 4'hF, 4'h4, 19, 4'hB, 8'hA4};
        vecs[12] = '{16'h1234, 4'h0, 4'hF, 4'h4, 20, 4'hF, 8'hFF};
        vecs[13] = '{16'h1234, 4'h0, 4'hF, 4'h0, 3,  4'hF, 8'hFF};
        vecs[14] = '{16'h0080, 4'h1, 4'h5, 4'hF, 3,  4'hE, 8'h40};
        vecs[15] = '{16'h0080, 4'h1, 4'h5, 4'hF, 11, 4'hF, 8'hFF};
        vecs[16] = '{16'h0080, 4'h1, 4'h5, 4'hF, 19, LZ_AN2, LZ_SEG2};
        vecs[17] = '{16'h0080, 4'h1, 4'h5, 4'hF, 27, 4'hF, 8'hFF};
        vecs[18] = '{16'h0070, 4'h0, 4'hF, 4'hF, 3,  4'hE, 8'hC0};
        vecs[19] = '{16'h0070, 4'h0, 4'hF, 4'hF, 11, 4'hD, 8'hF8};
        vecs[20] = '{16'h0070, 4'h0, 4'hF, 4'hF, 19, LZ_AN2, LZ_SEG2};
        vecs[21] = '{16'h0070, 4'h0, 4'hF, 4'hF, 27, LZ_AN3, LZ_SEG3};
        vecs[22] = '{16'hE000, 4'h8, 4'hF, 4'hF, 27, 4'h7, 8'h06};

        // Table: sample frame 2 (states 32..63) at frame offset s; pwm_cnt equals s mod 16 there
        for (int i = 0; i < 23; i++) begin
            start(vecs[i].value, vecs[i].dp, vecs[i].en, vecs[i].br);
            goto(33 + vecs[i].s);
            chk($sformatf("vec%0d_an", i), {12'h0, an}, {12'h0, vecs[i].exp_an});
            chk($sformatf("vec%0d_seg", i), {8'h0, seg}, {8'h0, vecs[i].exp_seg});
        end

        // frame_tick once per 32 cycles, never more than one anode low
        start(16'h1234, 4'h0, 4'hF, 4'hF);
        for (int c = 2; c <= 100; c++) begin
            goto(c);
            chk($sformatf("tick_c%0d", c), {15'h0, frame_tick}, {15'h0, (c % 32 == 0)});
            chk($sformatf("onehot_an_c%0d", c), {15'h0, ($countones(~an) <= 1)}, 16'h0001);
        end

        // Double buffering: back-to-back mid-frame loads, then a load on the boundary edge 64
        start(16'h1234, 4'h0, 4'hF, 4'hF);
        goto(36);
        chk("db_f2_an", {12'h0, an}, 16'h000E);
        chk("db_f2_seg", {8'h0, seg}, 16'h0099);
        goto(39);
        value = 16'h5555; load = 1'b1;
        @(negedge clk);
        value = 16'hABCD;
        @(negedge clk);
        load = 1'b0;
        goto(63);
        value = 16'h0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        goto(68);
        chk("db_f3_d0_seg", {8'h0, seg}, 16'h00A1);
        goto(76);
        chk("db_f3_d1_seg", {8'h0, seg}, 16'h00C6);
        goto(84);
        chk("db_f3_d2_seg", {8'h0, seg}, 16'h0083);
        goto(92);
        chk("db_f3_d3_an", {12'h0, an}, 16'h0007);
        chk("db_f3_d3_seg", {8'h0, seg}, 16'h0088);
        goto(100);
        chk("db_f4_d0_an", {12'h0, an}, 16'h000E);
        chk("db_f4_d0_seg", {8'h0, seg}, 16'h00C0);
        goto(124);
        chk("db_f4_d3_an", {12'h0, an}, {12'h0, LZ_AN3});
        chk("db_f4_d3_seg", {8'h0, seg}, {8'h0, LZ_SEG3});

        // Asynchronous reset while a digit is lit, then restart from digit 0
        start(16'h1234, 4'h0, 4'hF, 4'hF);
        goto(36);
        chk("ar_pre_an", {12'h0, an}, 16'h000E);
        #2 rst = 1'b1;
        #1;
        chk("ar_an", {12'h0, an}, 16'h000F);
        chk("ar_seg", {8'h0, seg}, 16'h00FF);
        @(negedge clk);
        rst = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        goto(31);
        chk("ar_no_early_tick", {15'h0, frame_tick}, 16'h0000);
        goto(32);
        chk("ar_tick", {15'h0, frame_tick}, 16'h0001);
        goto(36);
        chk("ar_d0_an", {12'h0, an}, 16'h000E);
        chk("ar_d0_seg", {8'h0, seg}, 16'h0099);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
